// File: rtl/spi_bram_rx_fifo.sv
// Receive FIFO for an SPI slave: inferred simple dual-port RAM with registered read port.
// Optional watermark flag is compiled in when SPI_RX_FIFO_WMARK_EN is defined.
module spi_bram_rx_fifo #(
  parameter int DATAWIDTH = 8,
  parameter int ADDRWIDTH = 11,
  parameter int WEN_EDGE  = 1,
  parameter int WMARK     = 1024
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 clr,
  input  logic                 wen,
  input  logic [DATAWIDTH-1:0] wdata,
  input  logic                 ren,
  output logic [DATAWIDTH-1:0] rdata,
  output logic                 rvalid,
  output logic                 empty,
  output logic                 full,
  output logic [ADDRWIDTH:0]   count,
  output logic                 overflow,
  output logic                 underflow,
  output logic                 wmark
);

  localparam int DEPTH = 2 ** ADDRWIDTH;
  localparam logic [ADDRWIDTH:0]   CNT_DEPTH = (ADDRWIDTH + 1)'(DEPTH);
  localparam logic [ADDRWIDTH:0]   CNT_ONE   = (ADDRWIDTH + 1)'(1);
  localparam logic [ADDRWIDTH-1:0] PTR_ONE   = ADDRWIDTH'(1);

  logic [DATAWIDTH-1:0] mem_q [DEPTH];
  logic [ADDRWIDTH-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [ADDRWIDTH:0]   count_q, count_d;
  logic                 empty_q, empty_d, full_q, full_d;
  logic                 ovf_q, ovf_d, unf_q, unf_d;
  logic                 rvalid_q, rvalid_d;
  logic                 wen_q;
  logic [DATAWIDTH-1:0] rdata_q;
  logic                 wreq_s, wacc_s, racc_s;

  // Request and acceptance decode; clr masks both sides for its cycle.
  always_comb begin
    wreq_s = (WEN_EDGE != 0) ? (wen & ~wen_q) : wen;
    wacc_s = wreq_s & ~full_q & ~clr;
    racc_s = ren & ~empty_q & ~clr;
  end

  // Next-state for pointers, occupancy and error flags.
  always_comb begin
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    rvalid_d = 1'b0;
    if (clr) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
      ovf_d   = 1'b0;
      unf_d   = 1'b0;
    end else begin
      if (wacc_s) wptr_d = wptr_q + PTR_ONE;
      else        wptr_d = wptr_q;
      if (racc_s) rptr_d = rptr_q + PTR_ONE;
      else        rptr_d = rptr_q;
      case ({wacc_s, racc_s})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
      if (wreq_s & full_q) ovf_d = 1'b1;
      else                 ovf_d = ovf_q;
      if (ren & empty_q)   unf_d = 1'b1;
      else                 unf_d = unf_q;
      rvalid_d = racc_s;
    end
    empty_d = (count_d == '0);
    full_d  = (count_d == CNT_DEPTH);
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      rvalid_q <= 1'b0;
      wen_q    <= 1'b0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      rvalid_q <= rvalid_d;
      wen_q    <= wen;
    end
  end

  // RAM write port; kept free of reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wacc_s) mem_q[wptr_q] <= wdata;
  end

  // Registered read port; rdata holds between accepted reads and across clr.
  always_ff @(posedge clk) begin
    if (!rstn)       rdata_q <= '0;
    else if (racc_s) rdata_q <= mem_q[rptr_q];
    else             rdata_q <= rdata_q;
  end

`ifdef SPI_RX_FIFO_WMARK_EN
  localparam logic [ADDRWIDTH:0] CNT_WMARK = (ADDRWIDTH + 1)'(WMARK);
  logic wmark_q;

  // Watermark tracks the same next count that feeds count_q.
  always_ff @(posedge clk) begin
    if (!rstn) wmark_q <= 1'b0;
    else       wmark_q <= (count_d >= CNT_WMARK);
  end
  assign wmark = wmark_q;
`else
  assign wmark = 1'b0;
`endif

  assign rdata     = rdata_q;
  assign rvalid    = rvalid_q;
  assign empty     = empty_q;
  assign full      = full_q;
  assign count     = count_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule

// File: tb/tb_spi_bram_rx_fifo.sv
// Directed self-checking bench: depth-8 FIFO with edge-triggered writes plus a
// level-triggered twin used only to check the WEN_EDGE=0 write path.
module tb_spi_bram_rx_fifo;

`ifdef SPI_RX_FIFO_WMARK_EN
  localparam logic WM_ON = 1'b1;
`else
  localparam logic WM_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rstn, clr, wen, ren;
  logic [7:0] wdata;
  logic [7:0] rdata, l_rdata;
  logic       rvalid, empty, full, overflow, underflow, wmark;
  logic       l_rvalid, l_empty, l_full, l_overflow, l_underflow, l_wmark;
  logic [3:0] count, l_count;
  int         tests = 0;
  int         fails = 0;

  always #5 clk = ~clk;

  spi_bram_rx_fifo #(.DATAWIDTH(8), .ADDRWIDTH(3), .WEN_EDGE(1), .WMARK(4)) dut (
    .clk(clk), .rstn(rstn), .clr(clr), .wen(wen), .wdata(wdata), .ren(ren),
    .rdata(rdata), .rvalid(rvalid), .empty(empty), .full(full), .count(count),
    .overflow(overflow), .underflow(underflow), .wmark(wmark));

  spi_bram_rx_fifo #(.DATAWIDTH(8), .ADDRWIDTH(3), .WEN_EDGE(0), .WMARK(4)) dut_lvl (
    .clk(clk), .rstn(rstn), .clr(clr), .wen(wen), .wdata(wdata), .ren(ren),
    .rdata(l_rdata), .rvalid(l_rvalid), .empty(l_empty), .full(l_full), .count(l_count),
    .overflow(l_overflow), .underflow(l_underflow), .wmark(l_wmark));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    wen = 1'b1; wdata = d; step();
    wen = 1'b0; step();
  endtask

  task automatic do_clr();
    clr = 1'b1; step();
    clr = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0; clr = 1'b0; ren = 1'b0; wen = 1'b1; wdata = 8'h33;
    step(); step();
    tests++;
    if ({count, empty, full, rvalid, overflow, underflow, wmark} !== {4'd0, 1'b1, 5'b00000}) begin
      fails++;
      $display("FAIL reset_flags: got cnt=%0d e=%b f=%b v=%b o=%b u=%b w=%b expected cnt=0 e=1 others 0",
               count, empty, full, rvalid, overflow, underflow, wmark);
    end
    tests++;
    if (rdata !== 8'h00) begin fails++; $display("FAIL reset_rdata: got %h expected 00", rdata); end
    rstn = 1'b1;
    step(); step(); step();
    wen = 1'b0; step();
    tests++;
    if (count !== 4'd1) begin fails++; $display("FAIL reset_wen_held: got count %0d expected 1", count); end
  endtask

  task automatic test_edge_write();
    do_clr();
    wen = 1'b1; wdata = 8'hA5;
    for (int i = 0; i < 5; i++) step();
    wen = 1'b0; step();
    tests++;
    if (count !== 4'd1 || empty !== 1'b0) begin
      fails++; $display("FAIL edge_one_word: got count %0d empty %b expected 1 0", count, empty);
    end
    tests++;
    if (l_count !== 4'd5) begin fails++; $display("FAIL level_writes: got count %0d expected 5", l_count); end
    ren = 1'b1; step(); ren = 1'b0;
    tests++;
    if (rvalid !== 1'b1 || rdata !== 8'hA5 || empty !== 1'b1) begin
      fails++; $display("FAIL edge_readback: got v=%b d=%h e=%b expected 1 a5 1", rvalid, rdata, empty);
    end
    step();
  endtask

  task automatic test_order();
    do_clr();
    for (int i = 1; i <= 4; i++) push(8'(i));
    ren = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step();
      tests++;
      if (rvalid !== 1'b1 || rdata !== 8'(i)) begin
        fails++; $display("FAIL order_read%0d: got v=%b d=%h expected 1 %h", i, rvalid, rdata, 8'(i));
      end
    end
    ren = 1'b0;
    tests++;
    if (empty !== 1'b1) begin fails++; $display("FAIL order_empty: got %b expected 1", empty); end
    step();
    tests++;
    if (rvalid !== 1'b0) begin fails++; $display("FAIL order_rvalid_drop: got %b expected 0", rvalid); end
  endtask

  task automatic test_full();
    do_clr();
    for (int i = 0; i < 8; i++) push(8'h10 + 8'(i));
    tests++;
    if (full !== 1'b1 || count !== 4'd8 || overflow !== 1'b0) begin
      fails++; $display("FAIL full_8: got f=%b cnt=%0d o=%b expected 1 8 0", full, count, overflow);
    end
    push(8'hEE);
    tests++;
    if (full !== 1'b1 || count !== 4'd8 || overflow !== 1'b1) begin
      fails++; $display("FAIL full_ovf: got f=%b cnt=%0d o=%b expected 1 8 1", full, count, overflow);
    end
    ren = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      tests++;
      if (rvalid !== 1'b1 || rdata !== 8'h10 + 8'(i)) begin
        fails++; $display("FAIL full_read%0d: got v=%b d=%h expected 1 %h", i, rvalid, rdata, 8'h10 + 8'(i));
      end
    end
    ren = 1'b0;
    tests++;
    if (empty !== 1'b1 || full !== 1'b0) begin
      fails++; $display("FAIL full_drain: got e=%b f=%b expected 1 0", empty, full);
    end
    step();
  endtask

  task automatic test_underflow();
    do_clr();
    wen = 1'b1; wdata = 8'h5C; ren = 1'b1; step();
    tests++;
    if (underflow !== 1'b1 || count !== 4'd1 || rvalid !== 1'b0) begin
      fails++; $display("FAIL unf_same_cycle: got u=%b cnt=%0d v=%b expected 1 1 0", underflow, count, rvalid);
    end
    wen = 1'b0; step();
    tests++;
    if (rvalid !== 1'b1 || rdata !== 8'h5C || count !== 4'd0) begin
      fails++; $display("FAIL unf_readback: got v=%b d=%h cnt=%0d expected 1 5c 0", rvalid, rdata, count);
    end
    ren = 1'b0; step();
    tests++;
    if (underflow !== 1'b1 || rvalid !== 1'b0) begin
      fails++; $display("FAIL unf_sticky: got u=%b v=%b expected 1 0", underflow, rvalid);
    end
  endtask

  task automatic test_back_to_back();
    do_clr();
    push(8'h40);
    for (int k = 1; k <= 20; k++) begin
      wen = 1'b1; wdata = 8'h40 + 8'(k); ren = 1'b1; step();
      tests++;
      if (rvalid !== 1'b1 || rdata !== 8'h40 + 8'(k - 1) || count !== 4'd1) begin
        fails++; $display("FAIL wrap_pair%0d: got v=%b d=%h cnt=%0d expected 1 %h 1",
                          k, rvalid, rdata, count, 8'h40 + 8'(k - 1));
      end
      wen = 1'b0; ren = 1'b0; step();
    end
  endtask

  task automatic test_wmark_clr();
    do_clr();
    push(8'h61); push(8'h62); push(8'h63);
    tests++;
    if (wmark !== 1'b0 || count !== 4'd3) begin
      fails++; $display("FAIL wmark_below: got w=%b cnt=%0d expected 0 3", wmark, count);
    end
    wen = 1'b1; wdata = 8'h64; step();
    tests++;
    if (wmark !== WM_ON || count !== 4'd4) begin
      fails++; $display("FAIL wmark_rise: got w=%b cnt=%0d expected %b 4", wmark, count, WM_ON);
    end
    wen = 1'b0; step();
    for (int i = 5; i <= 9; i++) push(8'h60 + 8'(i));
    tests++;
    if (overflow !== 1'b1 || rdata !== 8'h53) begin
      fails++; $display("FAIL wmark_prefill: got o=%b d=%h expected 1 53", overflow, rdata);
    end
    clr = 1'b1; wen = 1'b1; ren = 1'b1; step();
    tests++;
    if (count !== 4'd0 || wmark !== 1'b0 || overflow !== 1'b0 || empty !== 1'b1 || rvalid !== 1'b0) begin
      fails++; $display("FAIL clr_state: got cnt=%0d w=%b o=%b e=%b v=%b expected 0 0 0 1 0",
                        count, wmark, overflow, empty, rvalid);
    end
    tests++;
    if (rdata !== 8'h53) begin fails++; $display("FAIL clr_rdata_hold: got %h expected 53", rdata); end
    clr = 1'b0; wen = 1'b0; ren = 1'b0; step();
    tests++;
    if (count !== 4'd0) begin fails++; $display("FAIL clr_after: got count %0d expected 0", count); end
  endtask

  task automatic test_reset_mid_read();
    do_clr();
    push(8'h77);
    ren = 1'b1; rstn = 1'b0; step();
    tests++;
    if (rvalid !== 1'b0 || rdata !== 8'h00 || count !== 4'd0) begin
      fails++; $display("FAIL reset_mid_read: got v=%b d=%h cnt=%0d expected 0 00 0", rvalid, rdata, count);
    end
    rstn = 1'b1; ren = 1'b0; step();
  endtask

  initial begin
    test_reset();
    test_edge_write();
    test_order();
    test_full();
    test_underflow();
    test_back_to_back();
    test_wmark_clr();
    test_reset_mid_read();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
